dispatch_ctrl: RTL
==================

# dispatch_ctrl

Two-wide in-order dispatch controller that sits directly after the rename/dispatch pipeline register. Each cycle it decides which of the two held uops can enter their issue queues (ALU, LSU, MDU) and the ROB, given the free-slot counts those structures report. When only the older uop can go, it tracks that inst0 is done and holds the rename/dispatch register with a stall. Younger uops never dispatch ahead of older ones.

## Interface
Parameters:
- QFREE_W, 4: width of each issue-queue free count.
- ROBFREE_W, 6: width of the ROB free count.

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  pipeline flush (mispredict/exception)
- in_valid0, in_valid1  in  1 each  slot valid bits from the rename/dispatch register
- in_q0, in_q1  in  2 each  target queue: 0=ALU, 1=LSU, 2=MDU, 3=NONE (ROB only, e.g. nop)
- alu_free, lsu_free, mdu_free  in  QFREE_W each  free entries, sampled this cycle
- rob_free  in  ROBFREE_W  free ROB entries
- disp_fire0, disp_fire1  out  1 each  slot dispatches this cycle
- q_enq_cnt  out  3x2  per-queue enqueue count this cycle (0..2), indexed by queue id
- rob_enq_cnt  out  2  ROB allocations this cycle (0..2)
- stall_up  out  1  hold the rename/dispatch register and the upstream stages

## Operation
- FSM with two states, registered:
  - PAIR: both valid slots of the held bundle are pending.
  - HALF: inst0 has already dispatched; only inst1 is pending.
- pend0 = in_valid0 && state==PAIR.
- pend1 = in_valid1.
- fire0 = pend0 && free(in_q0)>=1 && rob_free>=1.
  - free(NONE) is treated as unlimited.
- fire1 = pend1 && (fire0 || !pend0) && free(in_q1) >= 1+(fire0 && in_q1==in_q0) && rob_free >= 1+fire0.
  - Compare with zero-extended widths; there is no truncation of the +1.
- done = (!pend0 || fire0) && (!pend1 || fire1).
- stall_up = !done.
- Next state:
  - PAIR→HALF when fire0 && pend1 && !fire1.
  - HALF→PAIR when fire1.
  - Otherwise hold.
- q_enq_cnt[q] = (fire0 && in_q0==q) + (fire1 && in_q1==q), for q in 0..2.
- rob_enq_cnt = fire0 + fire1.
- flush or rst: state←PAIR. All fire, enq counts and stall_up are forced to 0 in that same cycle.
- Bundle with in_valid0=0 and in_valid1=1 is legal; it dispatches inst1 alone subject to the fire1 rule.

## Timing
- Decision is combinational from the current inputs plus the state register: 0-cycle latency from bundle presentation to fire.
- stall_up is combinational. The rename/dispatch register must hold its contents on the same edge at which stall_up=1.
- State updates on posedge clk. Reset value is PAIR; every output is 0 during reset.
- Flush has priority over all dispatch. A flush arriving while in HALF discards the pending inst1, with no fire.
- Free counts are trusted for the current cycle only. Enqueues this cycle are reflected by the queues next cycle.
- Both slots targeting one queue that has exactly 1 free: only inst0 fires, and the FSM moves to HALF.

## Structure
- Shared package (defines):
  - queue-id enum: ALU, LSU, MDU, NONE.
  - FSM state enum: PAIR, HALF.
  - QFREE_W and ROBFREE_W defaults.
- One natural sub-module, disp_res_check: pure combinational resource check computing fire0 and fire1 from queue ids, free counts and rob_free.
- The FSM and the output counts stay in the top module.

## Test plan
- Both ALU, alu_free=5, rob_free=10 → fire0=fire1=1, q_enq_cnt[ALU]=2, rob_enq_cnt=2, stall_up=0, state stays PAIR.
- inst0 LSU, inst1 LSU, lsu_free=1:
  - cycle 1: fire0=1, fire1=0, stall_up=1, →HALF.
  - cycle 2 with lsu_free=1: fire1=1, fire0=0, stall_up=0, →PAIR.
- rob_free=0, any bundle → no fire, stall_up=1; raise rob_free to 1 → only inst0 fires.
- inst0 MDU, mdu_free=0, inst1 ALU, alu_free=8 → neither fires (in-order), stall_up=1.
- In HALF, assert flush → outputs 0 that cycle, next state PAIR. Next bundle (ALU, NONE) → both fire, q_enq_cnt[ALU]=1, rob_enq_cnt=2.
- rst mid-HALF → outputs 0. After release, state is PAIR, and in_valid0=0, in_valid1=1 dispatches inst1 alone.

Source files
------------

// File: rtl/dispatch_ctrl_pkg.sv
// Shared types and default widths for the two-wide dispatch controller.
package dispatch_ctrl_pkg;

   typedef enum logic [1:0] {
      QAlu  = 2'd0,
      QLsu  = 2'd1,
      QMdu  = 2'd2,
      QNone = 2'd3
   } queue_e;

   typedef enum logic {
      StPair = 1'b0,
      StHalf = 1'b1
   } state_e;

   localparam int unsigned QFreeWDefault   = 4;
   localparam int unsigned RobFreeWDefault = 6;
   localparam int unsigned NumIssueQ       = 3;

endpackage

// File: rtl/dispatch_ctrl_res_check.sv
// Combinational resource check: decides which pending slots fit in their queues and the ROB.
module disp_res_check
   import dispatch_ctrl_pkg::*;
#(
   parameter int unsigned QFREE_W   = QFreeWDefault,
   parameter int unsigned ROBFREE_W = RobFreeWDefault
) (
   input  logic                 pend0,
   input  logic                 pend1,
   input  queue_e               q0,
   input  queue_e               q1,
   input  logic [QFREE_W-1:0]   alu_free,
   input  logic [QFREE_W-1:0]   lsu_free,
   input  logic [QFREE_W-1:0]   mdu_free,
   input  logic [ROBFREE_W-1:0] rob_free,
   output logic                 fire0,
   output logic                 fire1
);

   logic [QFREE_W:0]   free0;
   logic [QFREE_W:0]   free1;
   logic [QFREE_W:0]   need1;
   logic [ROBFREE_W:0] rob_need1;
   logic               q0_ok;
   logic               q1_ok;

   always_comb begin
      free0 = '0;
      unique case (q0)
         QAlu:    free0 = {1'b0, alu_free};
         QLsu:    free0 = {1'b0, lsu_free};
         QMdu:    free0 = {1'b0, mdu_free};
         default: free0 = '0;
      endcase
      free1 = '0;
      unique case (q1)
         QAlu:    free1 = {1'b0, alu_free};
         QLsu:    free1 = {1'b0, lsu_free};
         QMdu:    free1 = {1'b0, mdu_free};
         default: free1 = '0;
      endcase
   end

   // NONE targets only the ROB, so it never waits on a queue.
   assign q0_ok = (q0 == QNone) || (free0 >= (QFREE_W+1)'(1));
   assign fire0 = pend0 && q0_ok && (rob_free != '0);

   // inst1 needs one more entry when inst0 takes from the same queue this cycle.
   assign need1     = (fire0 && (q1 == q0)) ? (QFREE_W+1)'(2) : (QFREE_W+1)'(1);
   assign rob_need1 = fire0 ? (ROBFREE_W+1)'(2) : (ROBFREE_W+1)'(1);
   assign q1_ok     = (q1 == QNone) || (free1 >= need1);
   assign fire1     = pend1 && (fire0 || !pend0) && q1_ok && ({1'b0, rob_free} >= rob_need1);

endmodule

// File: rtl/dispatch_ctrl.sv
// Two-wide in-order dispatch controller with a PAIR/HALF tracker for partially dispatched bundles.
module dispatch_ctrl
   import dispatch_ctrl_pkg::*;
#(
   parameter int unsigned QFREE_W   = QFreeWDefault,
   parameter int unsigned ROBFREE_W = RobFreeWDefault
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 in_valid0,
   input  logic                 in_valid1,
   input  logic [1:0]           in_q0,
   input  logic [1:0]           in_q1,
   input  logic [QFREE_W-1:0]   alu_free,
   input  logic [QFREE_W-1:0]   lsu_free,
   input  logic [QFREE_W-1:0]   mdu_free,
   input  logic [ROBFREE_W-1:0] rob_free,
   output logic                 disp_fire0,
   output logic                 disp_fire1,
   output logic [2:0][1:0]      q_enq_cnt,
   output logic [1:0]           rob_enq_cnt,
   output logic                 stall_up
);

   state_e state_q;
   state_e state_d;
   logic   pend0;
   logic   pend1;
   logic   fire0;
   logic   fire1;
   logic   kill;

   assign pend0 = in_valid0 && (state_q == StPair);
   assign pend1 = in_valid1;
   assign kill  = rst || flush;

   disp_res_check #(
      .QFREE_W   (QFREE_W),
      .ROBFREE_W (ROBFREE_W)
   ) u_res_check (
      .pend0    (pend0),
      .pend1    (pend1),
      .q0       (queue_e'(in_q0)),
      .q1       (queue_e'(in_q1)),
      .alu_free (alu_free),
      .lsu_free (lsu_free),
      .mdu_free (mdu_free),
      .rob_free (rob_free),
      .fire0    (fire0),
      .fire1    (fire1)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StPair;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = StPair;
      end else begin
         unique case (state_q)
            StPair:  if (fire0 && pend1 && !fire1) state_d = StHalf;
            StHalf:  if (fire1) state_d = StPair;
            default: state_d = StPair;
         endcase
      end
   end

   always_comb begin
      disp_fire0  = fire0 && !kill;
      disp_fire1  = fire1 && !kill;
      rob_enq_cnt = 2'(disp_fire0) + 2'(disp_fire1);
      stall_up    = !kill && !((!pend0 || fire0) && (!pend1 || fire1));
      q_enq_cnt   = '0;
      for (int q = 0; q < NumIssueQ; q++) begin
         q_enq_cnt[q] = 2'(disp_fire0 && (in_q0 == 2'(q))) + 2'(disp_fire1 && (in_q1 == 2'(q)));
      end
   end

endmodule
